// File: rtl/frame_bram_fifo.sv
// frame_bram_fifo: store-and-forward frame buffer on a simple dual-port RAM.
// Frames become readable only on commit; dropped or overflowing frames rewind the write pointer.
module frame_bram_fifo #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 14,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_last,
  input  logic                  s_drop,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_last,
  output logic [ADDR_W:0]       frame_cnt,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0] PTR_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = 1;
  typedef enum logic {WRITE, DISCARD} state_t;
  state_t r_state, w_state_nxt;
  logic [DATA_W:0] r_mem [DEPTH];
  logic [DATA_W:0] r_rdata, r_q0, r_q1;
  logic [ADDR_W:0] r_wr_ptr, r_cmt_ptr, r_rd_ptr, w_wr_nxt, w_cmt_nxt;
  logic [ADDR_W:0] r_frame_cnt;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic [1:0] r_cnt;
  logic [2:0] w_occ;
  logic r_s_ready, r_inflight;
  logic w_acc, w_full, w_we, w_commit, w_drop, w_pop, w_fetch, w_idx0;
  assign s_ready   = r_s_ready;
  assign m_valid   = r_cnt != 2'd0;
  assign m_data    = r_q0[DATA_W-1:0];
  assign m_last    = r_q0[DATA_W];
  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
  assign w_acc  = s_valid && r_s_ready;
  assign w_full = (r_wr_ptr - r_rd_ptr) == PTR_FULL;
  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr_ptr;
    w_cmt_nxt   = r_cmt_ptr;
    w_we        = 1'b0;
    w_commit    = 1'b0;
    w_drop      = 1'b0;
    if (w_acc) begin
      if (r_state == DISCARD || w_full) begin
        w_wr_nxt    = r_cmt_ptr;
        w_drop      = s_last;
        w_state_nxt = s_last ? WRITE : DISCARD;
      end else begin
        w_we      = 1'b1;
        w_commit  = s_last && !s_drop;
        w_drop    = s_last && s_drop;
        w_wr_nxt  = w_drop ? r_cmt_ptr : r_wr_ptr + PTR_ONE;
        w_cmt_nxt = w_commit ? r_wr_ptr + PTR_ONE : r_cmt_ptr;
      end
    end
  end
  // Words in the output stage plus the one in flight from the RAM, net of this cycle's pop.
  assign w_pop   = m_valid && m_ready;
  assign w_occ   = {1'b0, r_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_fetch = (r_rd_ptr != r_cmt_ptr) && (w_occ < 3'd2);
  assign w_idx0  = (r_cnt - {1'b0, w_pop}) == 2'd0;
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr[ADDR_W-1:0]] <= {s_last, s_data};
    if (w_fetch) r_rdata <= r_mem[r_rd_ptr[ADDR_W-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WRITE;
      r_s_ready   <= 1'b0;
      r_wr_ptr    <= '0;
      r_cmt_ptr   <= '0;
      r_rd_ptr    <= '0;
      r_inflight  <= 1'b0;
      r_cnt       <= 2'd0;
      r_q0        <= '0;
      r_q1        <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_s_ready   <= 1'b1;
      r_wr_ptr    <= w_wr_nxt;
      r_cmt_ptr   <= w_cmt_nxt;
      r_rd_ptr    <= w_fetch ? r_rd_ptr + PTR_ONE : r_rd_ptr;
      r_inflight  <= w_fetch;
      r_cnt       <= r_cnt - {1'b0, w_pop} + {1'b0, r_inflight};
      r_q0        <= (r_inflight && w_idx0) ? r_rdata : (w_pop ? r_q1 : r_q0);
      r_q1        <= (r_inflight && !w_idx0) ? r_rdata : r_q1;
      r_frame_cnt <= r_frame_cnt + {{ADDR_W{1'b0}}, w_commit} - {{ADDR_W{1'b0}}, w_pop && r_q0[DATA_W]};
      r_drop_cnt  <= (w_drop && !(&r_drop_cnt)) ? r_drop_cnt + DROP_ONE : r_drop_cnt;
    end
  end
endmodule

// File: tb/tb_frame_bram_fifo.sv
// tb_frame_bram_fifo: directed and randomized frame traffic checked against a queue model.
module tb_frame_bram_fifo;
  localparam int DW = 64, AW = 4, CW = 3, DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic rst_n;
  logic s_valid = 1'b0, s_last = 1'b0, s_drop = 1'b0, m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, m_valid, m_last;
  logic [DW-1:0] m_data;
  logic [AW:0] frame_cnt;
  logic [CW-1:0] drop_cnt;
  int total = 0, bad = 0, n_out = 0, rdy_mode = 1, m_frames = 0, m_drops = 0, n0;
  bit force_ovf = 1'b0, stall = 1'b0;
  logic [DW:0] q[$];
  logic [DW-1:0] cur[$];
  logic [DW:0] e;
  logic [DW-1:0] st_d, last_out;
  logic st_l;

  frame_bram_fifo #(.DATA_W(DW), .ADDR_W(AW), .DROP_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_drop(s_drop),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frames accumulate in cur and move to q only when committed.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      cur.delete();
      m_frames = 0;
      m_drops = 0;
      stall = 1'b0;
    end else begin
      chk("frame_cnt", 64'(frame_cnt), 64'(m_frames));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
      if (stall) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", m_data, st_d);
        chk("stall_last", 64'(m_last), 64'(st_l));
      end
      if (m_valid && q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %0h expected no beat", m_data);
      end else if (m_valid && m_ready) begin
        e = q.pop_front();
        chk("m_data", m_data, e[DW-1:0]);
        chk("m_last", 64'(m_last), 64'(e[DW]));
        if (e[DW]) m_frames--;
        n_out++;
        last_out = m_data;
      end
      stall = m_valid && !m_ready;
      st_d = m_data;
      st_l = m_last;
      if (s_valid && s_ready) begin
        cur.push_back(s_data);
        if (s_last) begin
          if (s_drop || force_ovf || cur.size() > DEPTH) m_drops = (m_drops == (1 << CW) - 1) ? m_drops : m_drops + 1;
          else begin
            foreach (cur[i]) q.push_back({i == cur.size() - 1, cur[i]});
            m_frames++;
          end
          cur.delete();
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rdy_mode == 0 ? 1'b0 : rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? !m_ready : 1'($urandom_range(0, 1));
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l, input logic dr);
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    s_drop = dr;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_drop = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [DW-1:0] base, input logic dr);
    for (int i = 0; i < len; i++) beat(base + DW'(i), i == len - 1, dr && i == len - 1);
  endtask

  task automatic wait_out(input int target);
    int t;
    t = 0;
    while (n_out < target && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("wait_out_timeout", 64'(n_out), 64'(target));
  endtask

  task automatic drain;
    int t;
    t = 0;
    rdy_mode = 1;
    while ((q.size() != 0 || m_valid) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_timeout", 64'(t < 3000), 64'd1);
    idle(2);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("s_ready_before_edge", 64'(s_ready), 64'd0);
    idle(1);
    chk("s_ready_after_edge", 64'(s_ready), 64'd1);
    idle(2);
    // basic frame: m_valid two edges after the last beat, then 1..4 back to back
    send_frame(4, 64'd1, 1'b0);
    chk("basic_fc_commit", 64'(frame_cnt), 64'd1);
    @(negedge clk);
    chk("basic_valid_n0", 64'(m_valid), 64'd0);
    @(negedge clk);
    chk("basic_valid_n1", 64'(m_valid), 64'd0);
    @(negedge clk);
    chk("basic_valid_n2", 64'(m_valid), 64'd1);
    chk("basic_data1", m_data, 64'd1);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk("basic_data", m_data, 64'(k));
      chk("basic_last", 64'(m_last), 64'(k == 4));
    end
    @(negedge clk);
    chk("basic_fc_end", 64'(frame_cnt), 64'd0);
    chk("basic_valid_end", 64'(m_valid), 64'd0);
    #1;
    // s_drop frame followed by a good one
    n0 = n_out;
    send_frame(3, 64'h30, 1'b1);
    send_frame(5, 64'hA0, 1'b0);
    drain();
    chk("drop_cnt_flag", 64'(drop_cnt), 64'd1);
    chk("drop_beats", 64'(n_out - n0), 64'd5);
    chk("drop_last_out", last_out, 64'hA4);
    // overflow with the reader stalled
    rdy_mode = 0;
    idle(2);
    send_frame(10, 64'h100, 1'b0);
    force_ovf = 1'b1;
    send_frame(10, 64'h200, 1'b0);
    force_ovf = 1'b0;
    idle(2);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("ovf_frame_cnt", 64'(frame_cnt), 64'd1);
    n0 = n_out;
    drain();
    chk("ovf_first_beats", 64'(n_out - n0), 64'd10);
    chk("ovf_first_last", last_out, 64'h109);
    send_frame(10, 64'h300, 1'b0);
    drain();
    chk("ovf_third_beats", 64'(n_out - n0), 64'd20);
    chk("ovf_third_last", last_out, 64'h309);
    chk("ovf_drop_after", 64'(drop_cnt), 64'd2);
    // backpressure with m_ready toggling
    rdy_mode = 2;
    n0 = n_out;
    send_frame(8, 64'h400, 1'b0);
    wait_out(n0 + 8);
    chk("bp_last_out", last_out, 64'h407);
    // pointer wrap-around
    rdy_mode = 1;
    n0 = n_out;
    for (int f = 0; f < 20; f++) send_frame(7, 64'h1000 + DW'(f * 7), 1'b0);
    wait_out(n0 + 140);
    chk("wrap_last_out", last_out, 64'h1000 + 64'd139);
    chk("wrap_drop_cnt", 64'(drop_cnt), 64'd2);
    drain();
    // randomized traffic; frames that fit are started only when space is guaranteed
    for (int f = 0; f < 250; f++) begin
      int len, t;
      len = $urandom_range(1, 20);
      t = 0;
      rdy_mode = 3;
      if (len <= DEPTH)
        while (q.size() + len > DEPTH && t < 3000) begin
          @(posedge clk);
          #1;
          t++;
        end
      if (t >= 3000) chk("rand_space_timeout", 64'(q.size()), 64'(DEPTH - len));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        beat({$urandom, $urandom}, i == len - 1, $urandom_range(0, 4) == 0);
      end
    end
    drain();
    chk("drop_cnt_saturated", 64'(drop_cnt), 64'd7);
    // reset while a committed frame is mid-read and another is being written
    rdy_mode = 0;
    idle(2);
    send_frame(6, 64'h600, 1'b0);
    rdy_mode = 2;
    idle(3);
    beat(64'h700, 1'b0, 1'b0);
    beat(64'h701, 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data = 64'h702;
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_m_data", m_data, 64'd0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    chk("mid_rst_ready_back", 64'(s_ready), 64'd1);
    n0 = n_out;
    send_frame(4, 64'h800, 1'b0);
    drain();
    chk("post_rst_beats", 64'(n_out - n0), 64'd4);
    chk("post_rst_last", last_out, 64'h803);
    chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_bram_fifo.md
# frame_bram_fifo

Parametrised store-and-forward frame buffer built on a simple dual-port block RAM: a generalised successor to the team's fixed 64-bit × 14-bit BRAM test block. It sits between the MAC receive path and the IP/TCP parsers. Frames are written speculatively and become visible to the reader only when committed on their last beat. Frames flagged bad, or frames that overflow the buffer, are discarded by rewinding the write pointer.

## Interface
- DATA_W, 64, payload width per beat.
- ADDR_W, 14, RAM address width; DEPTH = 2^ADDR_W words; each word stores {last, data}.
- DROP_CNT_W, 16, width of the saturating drop counter.

- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  write beat valid.
- s_ready  out  1  write beat accepted when s_valid && s_ready.
- s_data  in  DATA_W  write payload.
- s_last  in  1  last beat of frame.
- s_drop  in  1  sampled with s_last; 1 = discard whole frame.
- m_valid  out  1  read beat valid.
- m_ready  in  1  read beat consumed when m_valid && m_ready.
- m_data  out  DATA_W  read payload.
- m_last  out  1  last beat of frame.
- frame_cnt  out  ADDR_W+1  committed frames not yet fully read out.
- drop_cnt  out  DROP_CNT_W  frames discarded by overflow or s_drop; saturates at all-ones.

## Operation
- Pointers are ADDR_W+1 bits and wrap naturally. The extra bit distinguishes full from empty.
  - wr_ptr: speculative write pointer.
  - cmt_ptr: commit pointer.
  - rd_ptr: next RAM word to fetch.
- used = wr_ptr − rd_ptr. free = DEPTH − used. Words already fetched into the read pipeline count as free.
- s_ready is 1 whenever out of reset. The writer never back-pressures; it drops instead.
- Writer FSM has two states, WRITE (reset state) and DISCARD.
  - WRITE, beat accepted, free>0: write {s_last, s_data} to mem[wr_ptr[ADDR_W-1:0]], then wr_ptr++.
    - If s_last && !s_drop: cmt_ptr ← wr_ptr+1 and frame_cnt++.
    - If s_last && s_drop: wr_ptr ← cmt_ptr and drop_cnt++.
  - WRITE, beat accepted, free==0: the beat is not written and wr_ptr ← cmt_ptr.
    - If s_last: drop_cnt++ and stay in WRITE.
    - Otherwise: go to DISCARD.
  - DISCARD: accept and ignore beats. On s_last: drop_cnt++ and go to WRITE.
- A frame longer than DEPTH is always dropped.
- Reader:
  - Fetches mem[rd_ptr] whenever rd_ptr ≠ cmt_ptr and the 2-entry output stage has room, then rd_ptr++.
  - RAM read latency is 1 cycle. Data lands in a 2-entry output register/skid stage that drives m_*.
  - The reader never sees uncommitted words, so no read/write collision on the same address is possible.
- frame_cnt:
  - +1 on commit; −1 on a handshake with m_last.
  - Both events in the same cycle leave it unchanged.
- Reset (asserted at any time, including mid-frame or mid-read):
  - All pointers 0, FSM to WRITE.
  - s_ready=0, m_valid=0, m_data=0, m_last=0, frame_cnt=0, drop_cnt=0.
  - RAM contents are not cleared but are unreachable.

## Timing
- s_ready rises on the first clk edge after rst_n deasserts.
- Commit latency: the last beat accepted at edge N makes cmt_ptr visible after edge N. The RAM fetch is issued in cycle N+1, and m_valid=1 after edge N+2.
- Throughput: 1 beat/cycle in and 1 beat/cycle out with m_ready held high. Writing and reading simultaneously run at full rate.
- While m_valid && !m_ready, m_data and m_last hold stable. No beat is lost or duplicated for any m_ready pattern.
- m_valid never depends combinationally on m_ready. m_ready may depend on m_valid.
- The drop decision for a beat is made in the cycle it is accepted. The wr_ptr rewind is visible one cycle later.

## Test plan
- Basic frame: ADDR_W=14, frame of 4 beats with data 1,2,3,4, m_ready=1 → m_valid rises 2 cycles after the last beat; outputs 1,2,3,4 in consecutive cycles with m_last on 4; frame_cnt goes 0→1→0.
- Drop flag: 3-beat frame with s_drop=1 on the last beat, then a 5-beat frame with data A0..A4 → only A0..A4 appear; drop_cnt=1; the second frame occupies RAM addresses 0..4.
- Overflow: ADDR_W=4, m_ready=0; send a 10-beat frame, then another 10-beat frame → second frame dropped, drop_cnt=1, frame_cnt=1. After raising m_ready, the first frame's 10 beats appear intact. A third 10-beat frame is then accepted.
- Backpressure: 8-beat frame, m_ready toggling 1,0,1,0… → each beat output exactly once and in order; m_data stable on every stalled cycle.
- Wrap-around: ADDR_W=4, 20 frames of 7 beats with incrementing data, m_ready=1 → all 140 beats output in order with correct m_last; drop_cnt=0.
- Reset mid-operation: pull rst_n low during beat 3 of a write while a committed frame is mid-read → m_valid=0, frame_cnt=0, drop_cnt=0 immediately. After release, a new 4-beat frame is delivered normally.
